normal: RTL and testbench



---
 rtl/normal.sv | 77 +++++++
 tb/tb_normal.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/normal.sv
// Normal-mode timekeeping core: 24-hour hh:mm clock advanced by a 1 Hz clk,
// with an internal seconds counter and a range-checked synchronous time load.
module normal #(
  parameter int unsigned SEC_PER_MIN = 60
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       set_time_flag,
  input  logic [4:0] i_hours,
  input  logic [5:0] i_minutes,
  output logic [4:0] o_hours,
  output logic [5:0] o_minutes
);

  // A 1-bit counter still covers the smallest legal SEC_PER_MIN of 2.
  localparam int unsigned SEC_W = (SEC_PER_MIN > 2) ? $clog2(SEC_PER_MIN) : 1;
  localparam logic [SEC_W-1:0] SEC_LAST = SEC_W'(SEC_PER_MIN - 1);
  localparam logic [5:0] MIN_LAST = 6'd59;
  localparam logic [4:0] HR_LAST  = 5'd23;

  logic [SEC_W-1:0] sec_q, sec_d;
  logic [5:0]       min_q, min_d;
  logic [4:0]       hr_q,  hr_d;

  logic load_ok;
  logic sec_wrap;
  logic min_wrap;
  logic hr_wrap;

  // Qualify the load request and detect the rollover points of each field.
  always_comb begin
    load_ok  = set_time_flag && (i_hours <= HR_LAST) && (i_minutes <= MIN_LAST);
    // >= rather than == keeps the counters self-correcting if ever out of range.
    sec_wrap = (sec_q >= SEC_LAST);
    min_wrap = (min_q >= MIN_LAST);
    hr_wrap  = (hr_q  >= HR_LAST);
  end

  // Next-state: an accepted load overrides counting, including rollover edges.
  always_comb begin
    sec_d = sec_q;
    min_d = min_q;
    hr_d  = hr_q;
    if (load_ok) begin
      sec_d = '0;
      min_d = i_minutes;
      hr_d  = i_hours;
    end else if (!sec_wrap) begin
      sec_d = sec_q + SEC_W'(1);
    end else begin
      sec_d = '0;
      if (!min_wrap) begin
        min_d = min_q + 6'd1;
      end else begin
        min_d = '0;
        hr_d  = hr_wrap ? '0 : (hr_q + 5'd1);
      end
    end
  end

  // Time registers; reset clears everything, including a partial minute.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sec_q <= '0;
      min_q <= '0;
      hr_q  <= '0;
    end else begin
      sec_q <= sec_d;
      min_q <= min_d;
      hr_q  <= hr_d;
    end
  end

  assign o_hours   = hr_q;
  assign o_minutes = min_q;

endmodule

// File: tb/tb_normal.sv
// Directed bench for the normal-mode timekeeping core (SEC_PER_MIN = 60).
module tb_normal;

  logic       clk;
  logic       rst;
  logic       set_time_flag;
  logic [4:0] i_hours;
  logic [5:0] i_minutes;
  logic [4:0] o_hours;
  logic [5:0] o_minutes;

  int unsigned n_checks;
  int unsigned n_errors;

  normal #(.SEC_PER_MIN(60)) dut (
    .clk           (clk),
    .rst           (rst),
    .set_time_flag (set_time_flag),
    .i_hours       (i_hours),
    .i_minutes     (i_minutes),
    .o_hours       (o_hours),
    .o_minutes     (o_minutes)
  );

  // 10 time-unit clock, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_time(input string tag, input int hh, input int mm);
    check({tag, ".hours"},   int'(o_hours),   hh);
    check({tag, ".minutes"}, int'(o_minutes), mm);
  endtask

  // Advance n rising edges, leaving time 1 unit after the last edge.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Present a load request across exactly one rising edge.
  task automatic load(input int hh, input int mm);
    set_time_flag = 1'b1;
    i_hours       = 5'(hh);
    i_minutes     = 6'(mm);
    tick(1);
    set_time_flag = 1'b0;
  endtask

  initial begin
    n_checks      = 0;
    n_errors      = 0;
    rst           = 1'b0;
    set_time_flag = 1'b0;
    i_hours       = '0;
    i_minutes     = '0;

    // Reset held low: zero before and across edges.
    #3;
    check_time("reset_pre_edge", 0, 0);
    tick(2);
    check_time("reset_held", 0, 0);
    #4;
    rst = 1'b1;
    #1;
    check_time("reset_release", 0, 0);
    tick(59);
    check_time("after_59", 0, 0);
    tick(1);
    check_time("after_60", 0, 1);

    // Load 10:30 then count one full minute.
    load(10, 30);
    check_time("load_1030", 10, 30);
    tick(59);
    check_time("load_1030_59", 10, 30);
    tick(1);
    check_time("load_1030_60", 10, 31);

    // Day wrap.
    load(23, 58);
    tick(60);
    check_time("wrap_60", 23, 59);
    tick(60);
    check_time("wrap_120", 0, 0);

    // Hour carry without day wrap.
    load(9, 59);
    tick(60);
    check_time("hour_carry", 10, 0);

    // Rejected loads mid-minute: sec 30 -> 31 on the ignored edge.
    tick(30);
    load(24, 0);
    check_time("bad_hours", 10, 0);
    tick(28);
    check_time("bad_hours_28", 10, 0);
    tick(1);
    check_time("bad_hours_29", 10, 1);
    load(5, 60);
    check_time("bad_minutes", 10, 1);
    tick(58);
    check_time("bad_minutes_58", 10, 1);
    tick(1);
    check_time("bad_minutes_59", 10, 2);

    // Flag pulse that does not span a rising edge.
    @(negedge clk);
    set_time_flag = 1'b1;
    i_hours       = 5'd3;
    i_minutes     = 6'd3;
    #2;
    set_time_flag = 1'b0;
    tick(1);
    check_time("short_pulse", 10, 2);

    // Load wins over a day rollover on the same edge.
    load(23, 59);
    tick(59);
    check_time("prio_pre", 23, 59);
    load(5, 5);
    check_time("prio_load", 5, 5);
    tick(59);
    check_time("prio_59", 5, 5);
    tick(1);
    check_time("prio_60", 5, 6);

    // Held flag freezes time at the input value with sec kept at 0.
    set_time_flag = 1'b1;
    i_hours       = 5'd7;
    i_minutes     = 6'd7;
    tick(100);
    check_time("hold", 7, 7);
    set_time_flag = 1'b0;
    tick(59);
    check_time("hold_59", 7, 7);
    tick(1);
    check_time("hold_60", 7, 8);

    // Asynchronous reset mid-minute with a load pending.
    load(12, 34);
    tick(20);
    check_time("pre_reset", 12, 34);
    set_time_flag = 1'b1;
    i_hours       = 5'd12;
    i_minutes     = 6'd34;
    #1;
    rst = 1'b0;
    #1;
    check_time("async_reset", 0, 0);
    tick(1);
    check_time("async_reset_edge", 0, 0);
    set_time_flag = 1'b0;
    #3;
    rst = 1'b1;
    tick(59);
    check_time("rel_59", 0, 0);
    tick(1);
    check_time("rel_60", 0, 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
